b_mcp_send: RTL and testbench

B_MCP_SEND -- requirements
Module: b_mcp_send

---
 rtl/b_mcp_send_if.sv | 36 +++
 rtl/b_mcp_send.sv | 127 ++++++++++++
 tb/tb_b_mcp_send.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/b_mcp_send_if.sv
// b_mcp_send_if: handshake and data bundle for the mcp sender.
// master = requester / receive side, slave = b_mcp_send.
interface b_mcp_send_if #(
  parameter int DW = 8
);
  logic [DW-1:0] bdata_in;
  logic          bsend;
  logic          bready;
  logic [DW-1:0] adata_out;
  logic          b_en_tgl;
  logic          a_ack;
  logic          bdone;
  logic          btimeout;

  modport master (
    output bdata_in,
    output bsend,
    output a_ack,
    input  bready,
    input  adata_out,
    input  b_en_tgl,
    input  bdone,
    input  btimeout
  );

  modport slave (
    input  bdata_in,
    input  bsend,
    input  a_ack,
    output bready,
    output adata_out,
    output b_en_tgl,
    output bdone,
    output btimeout
  );
endinterface

// File: rtl/b_mcp_send.sv
// b_mcp_send: MCP transmit side, held data + enable toggle, synced ack.
// Optional ack timeout: define B_MCP_SEND_TIMEOUT_EN.
module b_mcp_send #(
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic         bclk,
  input logic         brst_n,
  b_mcp_send_if.slave bif
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] adata_q, adata_d;
  logic          tgl_q, tgl_d;
  logic          s1_q, s2_q, s3_q;
  logic          bdone_q, bdone_d;
  logic          accept;
  logic          ack_pulse;
  logic          to_hit;

  if (TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be at least 2");
  end

  assign ack_pulse = s2_q ^ s3_q;
  assign accept    = bif.bsend & (state_q == IDLE);

`ifdef B_MCP_SEND_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ?
                      $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bto_q, bto_d;

  assign to_hit = (state_q == WAIT_ACK) &
                  ~ack_pulse &
                  (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    bto_d = to_hit;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK &&
                 !ack_pulse) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      cnt_q <= '0;
      bto_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bto_q <= bto_d;
    end
  end

  assign bif.btimeout = bto_q;
`else
  assign to_hit       = 1'b0;
  assign bif.btimeout = 1'b0;
`endif

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ack wins over a timeout landing in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_pulse || to_hit) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    adata_d = adata_q;
    tgl_d   = tgl_q;
    bdone_d = (state_q == WAIT_ACK) & ack_pulse;
    if (accept) begin
      adata_d = bif.bdata_in;
      tgl_d   = ~tgl_q;
    end
  end

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      adata_q <= '0;
      tgl_q   <= 1'b0;
      bdone_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      adata_q <= adata_d;
      tgl_q   <= tgl_d;
      bdone_q <= bdone_d;
      s1_q    <= bif.a_ack;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign bif.bready    = (state_q == IDLE);
  assign bif.adata_out = adata_q;
  assign bif.b_en_tgl  = tgl_q;
  assign bif.bdone     = bdone_q;

endmodule

// File: tb/tb_b_mcp_send.sv
// tb_b_mcp_send: directed checks of b_mcp_send.
// Timeout checks run when B_MCP_SEND_TIMEOUT_EN is defined.
module tb_b_mcp_send;

  localparam int DW   = 8;
  localparam int TCYC = 16;

  logic bclk   = 1'b0;
  logic brst_n = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;

  b_mcp_send_if #(.DW(DW)) bif ();

  b_mcp_send #(
    .DW          (DW),
    .TIMEOUT_CYC (TCYC)
  ) u_dut (
    .bclk   (bclk),
    .brst_n (brst_n),
    .bif    (bif.slave)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string       tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge bclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] w [3];
  int   acc_n, done_n, ack_at, done_cyc;
  logic prev_tgl;
  int   to_cyc;

  initial begin
    bif.bsend    = 1'b0;
    bif.bdata_in = '0;
    bif.a_ack    = 1'b0;
    #12;
    chk("rst_bready", bif.bready, 1);
    chk("rst_adata", bif.adata_out, 0);
    chk("rst_tgl", bif.b_en_tgl, 0);
    chk("rst_bdone", bif.bdone, 0);
    chk("rst_bto", bif.btimeout, 0);
    brst_n = 1'b1;

    // first word
    bif.bsend    = 1'b1;
    bif.bdata_in = 8'hA5;
    tick;
    chk("acc_adata", bif.adata_out, 8'hA5);
    chk("acc_tgl", bif.b_en_tgl, 1);
    chk("acc_bready", bif.bready, 0);

    // bsend/bdata ignored while waiting
    bif.bdata_in = 8'h3C;
    tick;
    tick;
    chk("wait_adata", bif.adata_out, 8'hA5);
    chk("wait_tgl", bif.b_en_tgl, 1);

    // ack latency: edges k, k+1, k+2
    bif.a_ack = 1'b1;
    tick;
    chk("lat_k_bready", bif.bready, 0);
    tick;
    chk("lat_k1_bready", bif.bready, 0);
    chk("lat_k1_bdone", bif.bdone, 0);
    tick;
    chk("lat_k2_bready", bif.bready, 1);
    chk("lat_k2_bdone", bif.bdone, 1);
    bif.bsend = 1'b0;
    tick;
    chk("lat_k3_bdone", bif.bdone, 0);
    chk("lat_k3_adata", bif.adata_out, 8'hA5);
    chk("lat_k3_tgl", bif.b_en_tgl, 1);

    // spurious ack while idle
    bif.a_ack = 1'b0;
    repeat (5) begin
      tick;
      chk("idle_bdone", bif.bdone, 0);
      chk("idle_bready", bif.bready, 1);
    end

    // back-to-back with ack 5 cycles later
    w[0]     = 8'h01;
    w[1]     = 8'h02;
    w[2]     = 8'h03;
    acc_n    = 0;
    done_n   = 0;
    ack_at   = -1;
    done_cyc = -1;
    prev_tgl = bif.b_en_tgl;
    bif.bdata_in = w[0];
    bif.bsend    = 1'b1;
    for (int c = 0; c < 80 && done_n < 3; c++) begin
      tick;
      if (bif.b_en_tgl !== prev_tgl) begin
        prev_tgl = bif.b_en_tgl;
        chk("b2b_data", bif.adata_out, w[acc_n]);
        if (acc_n > 0)
          chk("b2b_gap", c, done_cyc + 1);
        acc_n++;
        ack_at = c + 5;
        if (acc_n < 3) bif.bdata_in = w[acc_n];
        else           bif.bsend    = 1'b0;
      end
      if (bif.bdone) begin
        done_n++;
        done_cyc = c;
      end
      if (c == ack_at) bif.a_ack = ~bif.a_ack;
    end
    chk("b2b_acc_n", acc_n, 3);
    chk("b2b_done_n", done_n, 3);

    // reset mid-transfer
    bif.bsend    = 1'b1;
    bif.bdata_in = 8'h77;
    tick;
    bif.bsend = 1'b0;
    chk("mid_bready", bif.bready, 0);
    tick;
    brst_n = 1'b0;
    bif.a_ack = 1'b0;
    #1;
    chk("mid_rst_bready", bif.bready, 1);
    chk("mid_rst_tgl", bif.b_en_tgl, 0);
    chk("mid_rst_adata", bif.adata_out, 0);
    #3;
    brst_n = 1'b1;
    repeat (3) begin
      tick;
      chk("post_rst_bdone", bif.bdone, 0);
      chk("post_rst_bready", bif.bready, 1);
    end

    // no-ack transfer
    bif.bsend    = 1'b1;
    bif.bdata_in = 8'h5A;
    tick;
    bif.bsend = 1'b0;
    chk("na_adata", bif.adata_out, 8'h5A);
`ifdef B_MCP_SEND_TIMEOUT_EN
    to_cyc = -1;
    for (int c = 1; c <= 40 && to_cyc < 0; c++) begin
      tick;
      chk("to_no_bdone", bif.bdone, 0);
      if (bif.btimeout) begin
        to_cyc = c;
        chk("to_bready", bif.bready, 1);
      end
    end
    chk("to_cycle", to_cyc, TCYC);
    tick;
    chk("to_one_pulse", bif.btimeout, 0);
    bif.a_ack = ~bif.a_ack;
    repeat (5) begin
      tick;
      chk("late_bdone", bif.bdone, 0);
      chk("late_bready", bif.bready, 1);
    end
`else
    to_cyc = 0;
    repeat (40) begin
      tick;
      if (bif.btimeout) to_cyc++;
    end
    chk("na_bready", bif.bready, 0);
    chk("na_bto_cnt", to_cyc, 0);
    bif.a_ack = ~bif.a_ack;
    repeat (3) tick;
    chk("na_bdone", bif.bdone, 1);
    chk("na_end_bready", bif.bready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
